mem_map_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU IO bus; second IO slot beside the SPI peripheral.
- Consumes the decoder's per-slot enable, write enable and IO address, plus CPU store data.
- Returns read data to the top-level load-data mux (rd_src select 2).
- Buffers bytes in a small FIFO and serialises 8N1 frames on `tx`.

---
 rtl/mem_map_uart_tx_pkg.sv | 42 ++++
 rtl/mem_map_uart_tx_sync_fifo.sv | 57 +++++
 rtl/mem_map_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_mem_map_uart_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - uart_state_e : transmitter FSM states (PARITY only when MEM_MAP_UART_PARITY_EN)
//   - register offsets and STATUS bit positions
//   - even_parity(): XOR of a data byte
// Optional build macro: MEM_MAP_UART_PARITY_EN (adds an even parity bit to each frame).
package mem_map_uart_tx_pkg;

`ifdef MEM_MAP_UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;
    localparam logic UART_PARITY_PRESENT = 1'b1;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
    localparam logic UART_PARITY_PRESENT = 1'b0;
`endif

    localparam logic [7:0] UART_TXDATA_ADDR = 8'h00;
    localparam logic [7:0] UART_STATUS_ADDR = 8'h04;

    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_EMPTY_BIT  = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 4;
    localparam int STAT_COUNT_MSB  = 7;
    localparam int STAT_PARITY_BIT = 8;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_map_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
//   clk, rst (sync, active-low) ; push/din write side ; pop/dout read side
//   full, empty, count ($clog2(DEPTH)+1 bits)
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage has no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/mem_map_uart_tx.sv
// Memory-mapped UART transmitter (IO slot 1).
//   clk, rst (sync, active-low)
//   en, we, addr, wd : IO decoder slot select, write enable, offset, store data
//   rd               : register read data, zero when en=0
//   tx               : serial output, idle high
//   irq_empty        : FIFO empty and transmitter idle
// Registers: 0x00 TXDATA (write pushes wd[7:0]), 0x04 STATUS
//   {parity_present, count[3:0], overflow, empty, full, busy}.
// Optional build macro: MEM_MAP_UART_PARITY_EN (even parity bit between data and stop).
module mem_map_uart_tx
    import mem_map_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [7:0]  addr,
    output logic [31:0] rd,
    output logic        tx,
    output logic        irq_empty
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
`ifdef MEM_MAP_UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              wr_txdata;
    logic              wr_status;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [FCW-1:0]    fifo_count;
    logic              bit_end;
    logic              load_frame;
    logic              unused_wd_bits;

    assign unused_wd_bits = ^wd[31:8];

    assign wr_txdata = en && we && (addr == UART_TXDATA_ADDR);
    assign wr_status = en && we && (addr == UART_STATUS_ADDR);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A push into a full FIFO is lost unless the FSM pops on the same edge.
    // Set has priority over a software clear on the same edge.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_status && wd[STAT_OVF_BIT]) overflow_d = 1'b0;
        if (wr_txdata && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        load_frame = 1'b0;
`ifdef MEM_MAP_UART_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!fifo_empty) load_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef MEM_MAP_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Next bit is shift_q[1] because the shift lands this edge.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef MEM_MAP_UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: go straight to START when data waits.
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load_frame) begin
            state_d = START;
            shift_d = fifo_dout;
            tx_d    = 1'b0;
`ifdef MEM_MAP_UART_PARITY_EN
            parity_d = even_parity(fifo_dout);
`endif
        end
    end

    assign fifo_pop = load_frame;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef MEM_MAP_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef MEM_MAP_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign irq_empty = fifo_empty && (state_q == IDLE);

    always_comb begin
        rd = '0;
        if (en && (addr == UART_STATUS_ADDR)) begin
            rd[STAT_BUSY_BIT]                  = (state_q != IDLE);
            rd[STAT_FULL_BIT]                  = fifo_full;
            rd[STAT_EMPTY_BIT]                 = fifo_empty;
            rd[STAT_OVF_BIT]                   = overflow_q;
            rd[STAT_COUNT_MSB:STAT_COUNT_LSB]  = 4'(fifo_count);
            rd[STAT_PARITY_BIT]                = UART_PARITY_PRESENT;
        end
    end

endmodule

// File: tb/tb_mem_map_uart_tx.sv
module tb_mem_map_uart_tx;

`ifdef MEM_MAP_UART_PARITY_EN
    localparam int          FRAME    = 44;
    localparam logic [31:0] STAT_PAR = 32'h100;
`else
    localparam int          FRAME    = 40;
    localparam logic [31:0] STAT_PAR = 32'h0;
`endif
    localparam int STOP_MID = FRAME - 2;

    logic        clk, rst, en, we, tx, irq_empty;
    logic [31:0] wd, rd;
    logic [7:0]  addr;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    int  cyc         = 0;
    int  prev_start  = -1;
    bit  contig_mode = 0;

    mem_map_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .wd        (wd),
        .addr      (addr),
        .rd        (rd),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        en = 1; we = 1; addr = a; wd = d;
        @(negedge clk);
        en = 0; we = 0;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
        en = 1; we = 0; addr = a;
        #1;
        d = rd;
        en = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (irq_empty !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'b0, irq_empty}, 32'h1);
    endtask

    // Monitor: decodes frames from tx, compares against the expected-byte queue.
    initial begin : monitor
        bit         active;
        int         cnt;
        logic [7:0] byte_rx;
        logic       par_rx;
        logic [7:0] e;
        active  = 0;
        cnt     = 0;
        byte_rx = '0;
        par_rx  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1;
                    cnt    = 0;
                    if (contig_mode && prev_start >= 0)
                        check("frame_gap", cyc - prev_start, FRAME);
                    prev_start = cyc;
                end
            end else begin
                cnt++;
                if (cnt == 2)
                    check("start_bit", {31'b0, tx}, 32'h0);
                if (cnt >= 6 && cnt <= 34 && ((cnt - 2) % 4) == 0)
                    byte_rx[(cnt - 6) / 4] = tx;
                if (cnt == 38 && FRAME == 44)
                    par_rx = tx;
                if (cnt == STOP_MID) begin
                    check("stop_bit", {31'b0, tx}, 32'h1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got %h expected none", byte_rx);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", {24'b0, byte_rx}, {24'b0, e});
                        if (FRAME == 44)
                            check("parity_bit", {31'b0, par_rx}, {31'b0, ^e});
                    end
                    active = 0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r;
        int lows;
        en = 0; we = 0; wd = '0; addr = '0; rst = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_irq", {31'b0, irq_empty}, 32'h1);
        read_reg(8'h04, r);
        check("rst_status", r, 32'h4 | STAT_PAR);
        rst = 1;
        @(negedge clk);
        addr = 8'h04;
        #1;
        check("rd_when_en0", rd, 32'h0);

        // Single frame 0xA5
        write_reg(8'h00, 32'hA5);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("a_tx_start", {31'b0, tx}, 32'h0);
        check("a_irq_busy", {31'b0, irq_empty}, 32'h0);
        read_reg(8'h04, r);
        check("a_status_busy", r, 32'h5 | STAT_PAR);
        read_reg(8'h00, r);
        check("a_txdata_read", r, 32'h0);
        repeat (FRAME - 1) @(negedge clk);
        read_reg(8'h04, r);
        check("a_status_last", r, 32'h5 | STAT_PAR);
        check("a_irq_last", {31'b0, irq_empty}, 32'h0);
        @(negedge clk);
        check("a_irq_done", {31'b0, irq_empty}, 32'h1);
        read_reg(8'h04, r);
        check("a_status_done", r, 32'h4 | STAT_PAR);

        // Five back-to-back bytes, contiguous frames
        contig_mode = 1;
        prev_start  = -1;
        for (int i = 1; i <= 5; i++) begin
            write_reg(8'h00, i);
            exp_q.push_back(8'(i));
        end
        read_reg(8'h04, r);
        check("b_status_full", r, 32'h43 | STAT_PAR);
        wait_idle(6 * FRAME + 20);
        contig_mode = 0;
        read_reg(8'h04, r);
        check("b_status_end", r, 32'h4 | STAT_PAR);

        // Six bytes: sixth dropped, overflow sticky, clear by writing bit3
        for (int i = 0; i < 6; i++) begin
            write_reg(8'h00, 32'h10 + i);
            if (i < 5) exp_q.push_back(8'(8'h10 + i));
        end
        read_reg(8'h04, r);
        check("c_status_ovf", r, 32'h4B | STAT_PAR);
        write_reg(8'h04, 32'h7);
        read_reg(8'h04, r);
        check("c_ovf_kept", r, 32'h4B | STAT_PAR);
        write_reg(8'h04, 32'h8);
        read_reg(8'h04, r);
        check("c_ovf_clear", r, 32'h43 | STAT_PAR);
        // Push into the full FIFO on the very edge the next frame pops.
        repeat (FRAME + 1 - 8) @(negedge clk);
        write_reg(8'h00, 32'h16);
        exp_q.push_back(8'h16);
        read_reg(8'h04, r);
        check("c_push_pop_full", r, 32'h43 | STAT_PAR);
        wait_idle(6 * FRAME + 20);

        // Reset mid-DATA of 0xFF with two bytes queued
        write_reg(8'h00, 32'hFF);
        write_reg(8'h00, 32'h11);
        write_reg(8'h00, 32'h22);
        repeat (12) @(negedge clk);
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        check("d_tx_after_rst", {31'b0, tx}, 32'h1);
        check("d_irq_after_rst", {31'b0, irq_empty}, 32'h1);
        read_reg(8'h04, r);
        check("d_status_after_rst", r, 32'h4 | STAT_PAR);
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("d_no_frames", lows, 0);

`ifdef MEM_MAP_UART_PARITY_EN
        write_reg(8'h00, 32'h07);
        exp_q.push_back(8'h07);
        wait_idle(FRAME + 20);
        read_reg(8'h04, r);
        check("e_status_parity", r, 32'h104);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
